// File: rtl/div_pkg.sv
// Shared types for the divider issue stage.
// The FSM state encoding and the all-ones fill used for divide-by-zero quotients.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        RELEASE
    } state_t;

    // Replicated to N bits to build the divide-by-zero quotient.
    localparam logic DIV_ALL_ONES = 1'b1;

endpackage

// File: rtl/div_req_fifo.sv
// Request buffer between decode and the divider issue FSM.
// Wrap-bit pointers give full/empty; clear empties the queue and wins over push.
module div_req_fifo
    import div_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [N-1:0]     wr_dividend,
    input  logic [N-1:0]     wr_divisor,
    output logic [TAG_W-1:0] rd_tag,
    output logic [N-1:0]     rd_dividend,
    output logic [N-1:0]     rd_divisor,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [TAG_W-1:0] tag_mem      [DEPTH];
    logic [N-1:0]     dividend_mem [DEPTH];
    logic [N-1:0]     divisor_mem  [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            tag_mem[wr_ptr[AW-1:0]]      <= wr_tag;
            dividend_mem[wr_ptr[AW-1:0]] <= wr_dividend;
            divisor_mem[wr_ptr[AW-1:0]]  <= wr_divisor;
        end
    end

    assign rd_tag      = tag_mem[rd_ptr[AW-1:0]];
    assign rd_dividend = dividend_mem[rd_ptr[AW-1:0]];
    assign rd_divisor  = divisor_mem[rd_ptr[AW-1:0]];
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/div_dispatch.sv
// Issue stage for the iterative divider: queues tagged requests, runs one divide at a time,
// and hands quotient/remainder/exception to writeback, with flush and local divide-by-zero handling.
module div_dispatch
    import div_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [N-1:0]     in_dividend,
    input  logic [N-1:0]     in_divisor,
    input  logic             flush,
    output logic             div_req,
    output logic [N-1:0]     div_dividend,
    output logic [N-1:0]     div_divisor,
    input  logic [N-1:0]     div_q,
    input  logic [N-1:0]     div_r,
    input  logic             div_ready,
    input  logic             div_exception,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [N-1:0]     wb_quot,
    output logic [N-1:0]     wb_rem,
    output logic             wb_exc,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             kill;
    logic             push;
    logic             pop;
    logic             capture;
    logic             zero_div;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] head_tag;
    logic [N-1:0]     head_dividend;
    logic [N-1:0]     head_divisor;
    logic [TAG_W-1:0] op_tag;
    logic [N-1:0]     op_dividend;
    logic [N-1:0]     op_divisor;

    // Flush discards the queue, so it blocks both the incoming push and the head pop.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (state == IDLE) && !fifo_empty && !flush;
    assign zero_div = (op_divisor == '0);

    div_req_fifo #(
        .N     (N),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .clear       (flush),
        .wr_tag      (in_tag),
        .wr_dividend (in_dividend),
        .wr_divisor  (in_divisor),
        .rd_tag      (head_tag),
        .rd_dividend (head_dividend),
        .rd_divisor  (head_divisor),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:    if (pop) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (div_ready) begin
                    capture   = !(kill || flush);
                    state_nxt = capture ? WB : RELEASE;
                end
            end
            WB:      if (flush || wb_ready) state_nxt = RELEASE;
            RELEASE: if (!div_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operands stay frozen from the pop until the next pop, covering ISSUE through RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_tag      <= '0;
            op_dividend <= '0;
            op_divisor  <= '0;
        end else if (pop) begin
            op_tag      <= head_tag;
            op_dividend <= head_dividend;
            op_divisor  <= head_divisor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                             kill <= 1'b0;
        else if ((state == ISSUE || state == WAIT) && flush) kill <= 1'b1;
        else if (state == RELEASE && !div_ready)             kill <= 1'b0;
    end

    // Divide-by-zero is judged from the held divisor; the divider's own result is ignored then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_tag  <= '0;
            wb_quot <= '0;
            wb_rem  <= '0;
            wb_exc  <= 1'b0;
        end else if (capture) begin
            wb_tag  <= op_tag;
            wb_quot <= zero_div ? {N{DIV_ALL_ONES}} : div_q;
            wb_rem  <= zero_div ? op_dividend : div_r;
            wb_exc  <= zero_div;
        end
    end

    assign div_req      = (state == ISSUE);
    assign div_dividend = op_dividend;
    assign div_divisor  = op_divisor;
    assign wb_valid     = (state == WB);
    assign busy         = (state != IDLE) || !fifo_empty;

    zero_div_flagged : assert property (@(posedge clk) disable iff (rst)
        (state == WAIT && div_ready && zero_div) |-> div_exception);

endmodule
